// File: rtl/bicubic_result_clamp_fifo.sv
// Round/shift/clamp stage for the bicubic DSP tap chain, feeding a small valid/ready pixel FIFO.
// Define BICUBIC_CLAMP_STATUS_EN to add saturating clip_low_cnt / clip_high_cnt status counters.
module bicubic_result_clamp_fifo #(
  parameter int DSP_LATENCY = 3,
  parameter int FRAC_BITS   = 14,
  parameter int OUT_WIDTH   = 8,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                 clk,
  input  logic                 areset,
  input  logic                 s_valid,
  output logic                 s_ready,
  input  logic signed [47:0]   dsp_result,
  output logic                 dsp_clken,
  output logic                 dsp_reset,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic [OUT_WIDTH-1:0] m_data
`ifdef BICUBIC_CLAMP_STATUS_EN
  ,
  output logic [15:0]          clip_low_cnt,
  output logic [15:0]          clip_high_cnt
`endif
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int RST_W = $clog2(DSP_LATENCY + 1) + 1;
  localparam logic signed [48:0] HALF = 49'sd1 <<< (FRAC_BITS - 1);

  logic [RST_W-1:0] rst_cnt_q;
  logic             dsp_reset_q;
  logic [CNT_W-1:0] count_q, count_d;

  // Hold the DSP chain in reset long enough to flush every pipeline register.
  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      rst_cnt_q   <= '0;
      dsp_reset_q <= 1'b1;
    end else if (dsp_reset_q) begin
      if (rst_cnt_q == RST_W'(DSP_LATENCY)) begin
        dsp_reset_q <= 1'b0;
      end else begin
        rst_cnt_q <= rst_cnt_q + 1'b1;
      end
    end
  end

  assign dsp_reset = dsp_reset_q;
  assign dsp_clken = !dsp_reset_q && (count_q < CNT_W'(FIFO_DEPTH));
  assign s_ready   = dsp_clken;

  logic [DSP_LATENCY-1:0] vld_q, vld_d;
  logic                   tail_vld;

  always_comb begin
    vld_d = vld_q;
    if (dsp_clken) begin
      vld_d = (vld_q << 1) | DSP_LATENCY'(s_valid);
    end
  end

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      vld_q <= '0;
    end else begin
      vld_q <= vld_d;
    end
  end

  assign tail_vld = vld_q[DSP_LATENCY-1];

  logic signed [48:0]   sum_full, q_full;
  logic                 clip_lo, clip_hi;
  logic [OUT_WIDTH-1:0] pix;

  // One extra bit keeps the rounding add from overflowing at the 48-bit extremes.
  always_comb begin
    sum_full = {dsp_result[47], dsp_result} + HALF;
    q_full   = sum_full >>> FRAC_BITS;
    clip_lo  = q_full[48];
    clip_hi  = !q_full[48] && (|q_full[47:OUT_WIDTH]);
    pix      = q_full[OUT_WIDTH-1:0];
    if (clip_lo) begin
      pix = '0;
    end else if (clip_hi) begin
      pix = '1;
    end
  end

  logic                 rnd_vld_q, rnd_lo_q, rnd_hi_q;
  logic [OUT_WIDTH-1:0] rnd_data_q;

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      rnd_vld_q  <= 1'b0;
      rnd_lo_q   <= 1'b0;
      rnd_hi_q   <= 1'b0;
      rnd_data_q <= '0;
    end else if (dsp_clken) begin
      rnd_vld_q <= tail_vld;
      if (tail_vld) begin
        rnd_data_q <= pix;
        rnd_lo_q   <= clip_lo;
        rnd_hi_q   <= clip_hi;
      end
    end
  end

  logic                 fifo_wr, fifo_rd;
  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [OUT_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic                 m_valid_q;
  logic [OUT_WIDTH-1:0] m_data_q;

  assign fifo_wr = rnd_vld_q && dsp_clken;
  assign fifo_rd = m_valid_q && m_ready;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (fifo_wr) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (fifo_rd) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    if (fifo_wr && !fifo_rd) begin
      count_d = count_q + 1'b1;
    end else if (!fifo_wr && fifo_rd) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (fifo_wr) begin
      mem_q[wr_ptr_q] <= rnd_data_q;
    end
  end

  // Output register presents the head entry; bypass covers the entry being written this edge.
  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      m_valid_q <= 1'b0;
      m_data_q  <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      m_valid_q <= (count_d != '0);
      if (count_d != '0) begin
        m_data_q <= (fifo_wr && (wr_ptr_q == rd_ptr_d)) ? rnd_data_q : mem_q[rd_ptr_d];
      end
    end
  end

  assign m_valid = m_valid_q;
  assign m_data  = m_data_q;

`ifdef BICUBIC_CLAMP_STATUS_EN
  logic [15:0] clip_low_q, clip_high_q;

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      clip_low_q  <= '0;
      clip_high_q <= '0;
    end else if (fifo_wr) begin
      if (rnd_lo_q && (clip_low_q != 16'hFFFF)) begin
        clip_low_q <= clip_low_q + 1'b1;
      end
      if (rnd_hi_q && (clip_high_q != 16'hFFFF)) begin
        clip_high_q <= clip_high_q + 1'b1;
      end
    end
  end

  assign clip_low_cnt  = clip_low_q;
  assign clip_high_cnt = clip_high_q;
`else
  logic unused_clip_flags;
  assign unused_clip_flags = rnd_lo_q ^ rnd_hi_q;
`endif

endmodule

// File: tb/tb_bicubic_result_clamp_fifo.sv
// Bench for bicubic_result_clamp_fifo: directed cases plus random traffic against a queue-based pixel model.
// Honours BICUBIC_CLAMP_STATUS_EN for the clip counters.
module tb_bicubic_result_clamp_fifo;
  localparam int LAT = 3;

  logic              clk = 1'b0;
  logic              areset;
  logic              s_valid;
  logic              s_ready;
  logic signed [47:0] dsp_result;
  logic              dsp_clken;
  logic              dsp_reset;
  logic              m_valid;
  logic              m_ready;
  logic [7:0]        m_data;
`ifdef BICUBIC_CLAMP_STATUS_EN
  logic [15:0]       clip_low_cnt, clip_high_cnt;
`endif

  always #5 clk = ~clk;

  bicubic_result_clamp_fifo dut (
    .clk(clk),
    .areset(areset),
    .s_valid(s_valid),
    .s_ready(s_ready),
    .dsp_result(dsp_result),
    .dsp_clken(dsp_clken),
    .dsp_reset(dsp_reset),
    .m_valid(m_valid),
    .m_ready(m_ready),
    .m_data(m_data)
`ifdef BICUBIC_CLAMP_STATUS_EN
    ,
    .clip_low_cnt(clip_low_cnt),
    .clip_high_cnt(clip_high_cnt)
`endif
  );

  int                 cmp_cnt = 0;
  int                 err_cnt = 0;
  int                 out_cnt = 0;
  int                 exp_lo = 0;
  int                 exp_hi = 0;
  logic [7:0]         exp_q[$];
  logic signed [47:0] pipe [LAT];
  logic signed [47:0] op_val;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    cmp_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // One clock: score the handshake, model the DSP chain, advance, check hold behaviour.
  task automatic cycle();
    logic       pv, pr;
    logic [7:0] pd;
    longint     q;
    pv = m_valid;
    pr = m_ready;
    pd = m_data;
    if (m_valid && m_ready) begin
      if (exp_q.size() == 0) begin
        check_eq("spurious_out", 1, 0);
      end else begin
        check_eq("pixel", m_data, exp_q.pop_front());
        out_cnt++;
      end
    end
    if (s_valid && dsp_clken) begin
      q = (longint'(op_val) + 64'sd8192) >>> 14;
      if (q < 0) begin
        exp_q.push_back(8'd0);
        exp_lo++;
      end else if (q > 255) begin
        exp_q.push_back(8'd255);
        exp_hi++;
      end else begin
        exp_q.push_back(8'(q));
      end
    end
    if (dsp_reset) begin
      for (int i = 0; i < LAT; i++) pipe[i] = '0;
    end else if (dsp_clken) begin
      for (int i = LAT - 1; i > 0; i--) pipe[i] = pipe[i-1];
      pipe[0] = op_val;
    end
    @(posedge clk);
    #1;
    dsp_result = pipe[LAT-1];
    if (pv && !pr) begin
      check_eq("hold_valid", m_valid, 1);
      check_eq("hold_data", m_data, pd);
    end
    @(negedge clk);
  endtask

  task automatic send(input logic v, input logic signed [47:0] val);
    s_valid = v;
    op_val  = val;
    cycle();
  endtask

  task automatic drain(input string tag);
    int n = 0;
    s_valid = 1'b0;
    m_ready = 1'b1;
    while ((exp_q.size() != 0 || m_valid) && n < 200) begin
      cycle();
      n++;
    end
    check_eq(tag, exp_q.size(), 0);
    repeat (LAT + 3) cycle();
  endtask

  task automatic do_reset();
    s_valid = 1'b0;
    #2;
    areset = 1'b1;
    #1;
    check_eq("rst_m_valid", m_valid, 0);
    check_eq("rst_m_data", m_data, 0);
    check_eq("rst_dsp_reset", dsp_reset, 1);
    check_eq("rst_clken", dsp_clken, 0);
    exp_q.delete();
    exp_lo = 0;
    exp_hi = 0;
    @(negedge clk);
    @(negedge clk);
    areset = 1'b0;
    for (int i = 1; i <= LAT + 1; i++) begin
      cycle();
      check_eq("rel_dsp_reset", dsp_reset, (i <= LAT));
    end
    check_eq("rel_clken", dsp_clken, 1);
    check_eq("rel_m_valid", m_valid, 0);
  endtask

  function automatic logic signed [47:0] rand_val();
    logic signed [47:0] v;
    case ($urandom_range(0, 4))
      0:       v = 48'($urandom_range(0, 256 * 16384));
      1:       v = -48'($urandom_range(1, 1 << 22));
      2:       v = 48'({$urandom(), $urandom()});
      3:       v = -48'($urandom_range(8190, 8194));
      default: begin
        v = 48'($urandom_range(0, 256)) <<< 14;
        v = v + 48'(8191 + $urandom_range(0, 1));
      end
    endcase
    return v;
  endfunction

  task automatic check_status();
`ifdef BICUBIC_CLAMP_STATUS_EN
    check_eq("clip_low_cnt", clip_low_cnt, exp_lo);
    check_eq("clip_high_cnt", clip_high_cnt, exp_hi);
`endif
  endtask

  initial begin
    int base;
    areset     = 1'b1;
    s_valid    = 1'b0;
    m_ready    = 1'b1;
    op_val     = '0;
    dsp_result = '0;
    for (int i = 0; i < LAT; i++) pipe[i] = '0;
    @(negedge clk);
    do_reset();

    // first-pixel latency: m_valid appears exactly LAT+2 edges after acceptance
    send(1'b1, 48'sh1E000);
    for (int k = 2; k <= LAT + 3; k++) begin
      send(1'b0, 48'sd0);
      check_eq("lat_m_valid", m_valid, (k == LAT + 2));
    end
    send(1'b1, 48'sh1DFFF);
    drain("drain_round");

    send(1'b1, -(48'sd1 <<< 14));
    send(1'b1, 48'sd300 <<< 14);
    drain("drain_clamp");
    check_status();

    // backpressure: six pixels against a stalled sink
    base = out_cnt;
    m_ready = 1'b0;
    for (int i = 1; i <= 6; i++) send(1'b1, 48'(i) <<< 14);
    for (int i = 0; i < 8; i++) send(1'b0, 48'sd0);
    check_eq("bp_clken", dsp_clken, 0);
    check_eq("bp_m_valid", m_valid, 1);
    check_eq("bp_head", m_data, 1);
    drain("drain_bp");
    check_eq("bp_outputs", out_cnt - base, 6);

    base = out_cnt;
    m_ready = 1'b1;
    send(1'b1, 48'sd10 <<< 14);
    send(1'b0, 48'sd99 <<< 14);
    send(1'b1, (48'sd20 <<< 14) + 48'sh2000);
    send(1'b1, 48'sd30 <<< 14);
    drain("drain_gaps");
    check_eq("gap_outputs", out_cnt - base, 3);

    // reset with pixels queued
    m_ready = 1'b0;
    for (int i = 0; i < 3; i++) send(1'b1, 48'(40 + i) <<< 14);
    for (int i = 0; i < 6; i++) send(1'b0, 48'sd0);
    check_eq("q3_m_valid", m_valid, 1);
    do_reset();
    base = out_cnt;
    drain("drain_post_reset");
    check_eq("post_reset_outputs", out_cnt - base, 0);
    check_status();

    for (int i = 0; i < 400; i++) begin
      m_ready = ($urandom_range(0, 9) < 7);
      s_valid = 1'(($urandom_range(0, 1)));
      op_val  = rand_val();
      cycle();
    end
    drain("drain_random");
    check_status();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: bench did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
